// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding for the debounce filter
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } db_state_t;

    // The accepted level is high while sitting in S_HIGH or qualifying a fall from it
    function automatic logic state_is_high(input db_state_t st);
        return (st == S_HIGH) || (st == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/debounce_fsm_sync_ff.sv
// rtl/debounce_fsm_sync_ff.sv - generic reset-to-0 flip-flop synchroniser chain
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "sync_ff: STAGES must be at least 2");
    end

    logic [STAGES-1:0] chain_q;

    // Shift the raw level through the chain; bit 0 is the metastability-exposed stage
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - synchronise and debounce a raw bouncy level into a clean registered level
module debounce_fsm #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    import debounce_pkg::*;

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $fatal(1, "debounce_fsm: STABLE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "debounce_fsm: SYNC_STAGES must be at least 2");
    end

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (s)
    );

    // Next state and qualification count; any opposite sample in a WAIT state restarts from scratch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State, count and the output decode all update together so out never sees the raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= state_is_high(state_d);
        end
    end

    assign out = out_q;

endmodule
